match_collector: RTL and testbench
==================================

# match_collector

Downstream stage of the Tanimoto comparator. Consumes the per-pair match bit and valid strobe, tracks which (query, reference) pair each result belongs to, and buffers the index pairs of matches in a FIFO. The FIFO drains over a valid/ready stream toward the host DMA. The block also reports run completion and FIFO overflow.

## Interface
- `ID_WIDTH`, 16: width of the query and reference indices.
- `FIFO_DEPTH`, 16: result FIFO entries; must be a power of two, ≥2.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous assert, active-low; deassertion is synchronous to `clk`.
- `i_Start` in 1: single-cycle pulse that begins a run.
- `i_RefCount` in ID_WIDTH: number of reference vectors per query; sampled at `i_Start`.
- `i_QueryCount` in ID_WIDTH: number of query vectors; sampled at `i_Start`.
- `i_Valid` in 1: comparator result strobe.
- `i_Match` in 1: comparator result bit; meaningful only when `i_Valid` is high.
- `o_Data` out 2*ID_WIDTH: matching pair, packed as {query_id, ref_id}.
- `o_Valid` out 1: `o_Data` is valid.
- `i_Ready` in 1: downstream accepts `o_Data`.
- `o_Overflow` out 1: sticky; a match was dropped because the FIFO was full.
- `o_Done` out 1: all results counted and the FIFO is empty.
- `o_MatchCnt` out 32: total matches in the run. Present only with `MATCH_COLLECTOR_CNT_EN`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `i_Start`. `i_Start` latches both counts, clears `ref_id`, `query_id`, `o_Overflow` and `o_MatchCnt`, and flushes the FIFO.
- Result ordering: references are the inner loop. On every result with `i_Valid` high in RUN:
  - If `ref_id == RefCount-1`, `ref_id` wraps to 0 and `query_id` increments.
  - Otherwise `ref_id` increments.
- A result with `i_Match` high pushes the pre-increment {query_id, ref_id} into the FIFO.
- RUN → DRAIN on the result with `ref_id == RefCount-1` and `query_id == QueryCount-1`.
- DRAIN → DONE when the FIFO is empty. `o_Done` is high in DONE.
- DONE → RUN on `i_Start`. DONE → IDLE never happens except through reset.
- `i_Valid` outside RUN is ignored: no count, no push.
- Either count equal to 0: `i_Start` goes straight to DRAIN, then DONE. No results are accepted.
- FIFO full and a push is required:
  - If a pop happens in the same cycle (`o_Valid & i_Ready`), the push is accepted.
  - Otherwise the entry is dropped and `o_Overflow` is set.
  - Counters advance either way.
- `i_Start` while in RUN or DRAIN restarts the run: counters clear, FIFO flushes, pending data is discarded.
- Counters are ID_WIDTH bits and never exceed count-1. No arithmetic overflow is possible.

## Timing
- Reset values:
  - `o_Valid`=0, `o_Data`=0, `o_Overflow`=0, `o_Done`=0, `o_MatchCnt`=0.
  - State IDLE, FIFO empty.
- Accepts one result per cycle, with no input backpressure.
- Match-to-output latency: result sampled at edge N; `o_Valid` high after edge N+1. The FIFO is first-word-fall-through with a registered output.
- `o_Data` and `o_Valid` hold stable while `o_Valid & !i_Ready`.
- `o_Overflow` is set at the edge of the dropped push and holds until the next `i_Start` or reset.
- `o_Done` rises on the edge after the last pop, or two edges after the final result if the FIFO is empty then.
- The first result may arrive on the cycle after `i_Start`. `i_Valid` coincident with `i_Start` is ignored.
- Reset asserted mid-run: all outputs clear immediately, independent of `clk`; FIFO contents are lost.

## Configuration
- Macro `MATCH_COLLECTOR_CNT_EN`.
- Defined:
  - `o_MatchCnt` port exists.
  - It increments on every result with `i_Valid & i_Match` in RUN, dropped entries included.
  - It saturates at 2^32-1 and clears on `i_Start`.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `tanimoto_pkg` holds:
  - The FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - The pair-packing helper and width constants, shared with the host-side unpacker.
- Sub-module `result_fifo`:
  - Synchronous FIFO with parameters `WIDTH` and `DEPTH`.
  - Ports: push, pop, full, empty, flush.
  - Pointers are log2(DEPTH)+1 bits so full and empty can be distinguished.
- Top level contains the FSM, the index counters, the overflow flag and the optional match counter.

## Test plan
- RefCount=3, QueryCount=2; matches at results 1 and 4; `i_Ready`=1 → output {0,1} then {1,1}; `o_Done` high; `o_Overflow`=0.
- FIFO_DEPTH=4, `i_Ready`=0, 6 consecutive matches → 4 entries held, `o_Overflow`=1. Then raise `i_Ready` → pairs {0,0}..{0,3} drain, then `o_Done`.
- FIFO full, `i_Ready`=1, and a match arrives in the same cycle → no drop; `o_Overflow` stays 0.
- RefCount=0 with `i_Start` → `o_Done` high within 2 cycles; a later `i_Valid`/`i_Match` produces no output.
- `i_Start` mid-run after 2 of 4 results → FIFO flushed, indices restart at {0,0}, `o_Overflow` cleared.
- `rst` asserted low mid-DRAIN with `o_Valid`=1 → `o_Valid`, `o_Done` and `o_Overflow` go low without waiting for a clock edge. With `MATCH_COLLECTOR_CNT_EN` defined, `o_MatchCnt` also reads 0.

Source files
------------

// File: rtl/tanimoto_pkg.sv
// -----------------------------------------------------------------------------
// tanimoto_pkg
//   Shared definitions for the Tanimoto comparator back end.
//   - mc_state_e : match_collector FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - TANIMOTO_ID_W / TANIMOTO_PAIR_W : default index and packed-pair widths
//   - pack_pair / pair_query / pair_ref : {query_id, ref_id} packing helpers,
//     also used by the host-side unpacker so both ends agree on the layout.
// -----------------------------------------------------------------------------
package tanimoto_pkg;

  localparam int TANIMOTO_ID_W   = 16;
  localparam int TANIMOTO_PAIR_W = 2 * TANIMOTO_ID_W;

  typedef logic [TANIMOTO_ID_W-1:0]   id_t;
  typedef logic [TANIMOTO_PAIR_W-1:0] pair_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_e;

  // Query index occupies the upper half, reference index the lower half.
  function automatic pair_t pack_pair(input id_t query_id, input id_t ref_id);
    return {query_id, ref_id};
  endfunction

  function automatic id_t pair_query(input pair_t pair);
    return pair[TANIMOTO_PAIR_W-1 -: TANIMOTO_ID_W];
  endfunction

  function automatic id_t pair_ref(input pair_t pair);
    return pair[TANIMOTO_ID_W-1:0];
  endfunction

endpackage

// File: rtl/match_collector_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Synchronous first-word-fall-through FIFO with a registered output stage.
//   The entry shown on o_data stays in the memory until it is popped, so the
//   total capacity is exactly DEPTH entries. A word pushed at edge N appears
//   on o_data/o_valid after edge N+1.
//
// Parameters
//   WIDTH : data width
//   DEPTH : number of entries, power of two, >= 2
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   i_flush  in   synchronous clear of all contents (wins over push/pop)
//   i_push   in   write request; accepted when not full or when popping
//   i_data   in   write data
//   i_pop    in   consumer handshake (o_valid & ready), removes the head
//   o_data   out  head entry (registered)
//   o_valid  out  o_data holds a valid head entry (registered)
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
//   o_count  out  number of stored entries
// -----------------------------------------------------------------------------
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit separates the full and empty cases.
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [PW-1:0]    w_count;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic             w_full;
  logic             w_push_ok;
  logic             w_valid_nxt;

  // Occupancy, push acceptance and next read pointer.
  always_comb begin
    w_count   = r_wr_ptr - r_rd_ptr;
    w_full    = (w_count == PW'(DEPTH));
    // When full, a same-cycle pop frees the slot the push lands in.
    w_push_ok = i_push & (~w_full | i_pop);
    if (i_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    // Only entries already in memory before this edge are presented next,
    // which gives the one-cycle push-to-output latency.
    w_valid_nxt = (r_wr_ptr != w_rd_ptr_nxt);
  end

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Registered head stage; reloading an unpopped head keeps it stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
    end else begin
      r_valid <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_data <= r_mem[w_rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_full  = w_full;
  assign o_empty = (w_count == {PW{1'b0}});
  assign o_count = w_count;

endmodule

// File: rtl/match_collector.sv
// -----------------------------------------------------------------------------
// match_collector
//   Collects comparator results, tracks the (query, reference) pair of each
//   result (references are the inner loop) and buffers the index pairs of
//   matches in result_fifo, which drains over a valid/ready stream.
//
// Optional feature: define MATCH_COLLECTOR_CNT_EN to add the o_MatchCnt
// saturating match counter. Without it the port and counter are absent.
//
// Parameters
//   ID_WIDTH   : width of the query and reference indices
//   FIFO_DEPTH : result FIFO entries (power of two, >= 2)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   i_Start      in   pulse that (re)starts a run
//   i_RefCount   in   references per query, sampled at i_Start
//   i_QueryCount in   number of queries, sampled at i_Start
//   i_Valid      in   comparator result strobe
//   i_Match      in   comparator result bit
//   o_Data       out  {query_id, ref_id} of a match
//   o_Valid      out  o_Data valid
//   i_Ready      in   downstream accepts o_Data
//   o_Overflow   out  sticky: a match was dropped on a full FIFO
//   o_Done       out  all results counted and FIFO drained
//   o_MatchCnt   out  matches in the run (MATCH_COLLECTOR_CNT_EN only)
// -----------------------------------------------------------------------------
module match_collector
  import tanimoto_pkg::*;
#(
  parameter int ID_WIDTH   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start,
  input  logic [ID_WIDTH-1:0]   i_RefCount,
  input  logic [ID_WIDTH-1:0]   i_QueryCount,
  input  logic                  i_Valid,
  input  logic                  i_Match,
  output logic [2*ID_WIDTH-1:0] o_Data,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic                  o_Overflow,
  output logic                  o_Done
`ifdef MATCH_COLLECTOR_CNT_EN
  ,
  output logic [31:0]           o_MatchCnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ID_WIDTH-1:0] ID_ZERO = {ID_WIDTH{1'b0}};
  localparam logic [ID_WIDTH-1:0] ID_ONE  = ID_WIDTH'(1);

  mc_state_e             r_state;
  mc_state_e             w_state_nxt;

  logic [ID_WIDTH-1:0]   r_ref_cnt;
  logic [ID_WIDTH-1:0]   r_query_cnt;
  logic [ID_WIDTH-1:0]   r_ref_id;
  logic [ID_WIDTH-1:0]   r_query_id;
  logic                  r_overflow;
  logic                  r_done;

  logic                  w_result;
  logic                  w_last_ref;
  logic                  w_last_qry;
  logic                  w_final;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_zero_run;
  logic                  w_drain_done;

  logic [2*ID_WIDTH-1:0] w_fifo_data;
  logic                  w_fifo_valid;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [PW-1:0]         w_fifo_count;

  // Result qualification and FIFO handshake decode.
  always_comb begin
    // A result coincident with i_Start belongs to no run and is ignored.
    w_result     = i_Valid & (r_state == ST_RUN) & ~i_Start;
    w_last_ref   = (r_ref_id == (r_ref_cnt - ID_ONE));
    w_last_qry   = (r_query_id == (r_query_cnt - ID_ONE));
    w_final      = w_result & w_last_ref & w_last_qry;
    w_push       = w_result & i_Match;
    w_pop        = w_fifo_valid & i_Ready;
    w_drop       = w_push & w_fifo_full & ~w_pop;
    w_zero_run   = (i_RefCount == ID_ZERO) | (i_QueryCount == ID_ZERO);
    // Nothing is pushed in DRAIN, so the FIFO is empty after this edge when
    // it is empty now or its last entry is being popped.
    w_drain_done = w_fifo_empty | ((w_fifo_count == PW'(1)) & w_pop);
  end

  // FSM next-state logic; i_Start restarts from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (i_Start) begin
      if (w_zero_run) begin
        w_state_nxt = ST_DRAIN;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (w_final) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run lengths and (query, reference) index counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref_cnt   <= ID_ZERO;
      r_query_cnt <= ID_ZERO;
      r_ref_id    <= ID_ZERO;
      r_query_id  <= ID_ZERO;
    end else if (i_Start) begin
      r_ref_cnt   <= i_RefCount;
      r_query_cnt <= i_QueryCount;
      r_ref_id    <= ID_ZERO;
      r_query_id  <= ID_ZERO;
    end else if (w_result) begin
      if (w_last_ref) begin
        r_ref_id <= ID_ZERO;
        // Wrap the query index on the final result so it never reaches
        // QueryCount.
        if (w_last_qry) begin
          r_query_id <= ID_ZERO;
        end else begin
          r_query_id <= r_query_id + ID_ONE;
        end
      end else begin
        r_ref_id <= r_ref_id + ID_ONE;
      end
    end
  end

  // Sticky overflow flag, cleared only by a new run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (i_Start) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Registered completion flag, one edge behind the DONE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE) & ~i_Start;
    end
  end

`ifdef MATCH_COLLECTOR_CNT_EN
  logic [31:0] r_match_cnt;

  // Saturating count of all matches in the run, dropped ones included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_match_cnt <= 32'd0;
    end else if (i_Start) begin
      r_match_cnt <= 32'd0;
    end else if (w_push && (r_match_cnt != 32'hFFFF_FFFF)) begin
      r_match_cnt <= r_match_cnt + 32'd1;
    end
  end

  assign o_MatchCnt = r_match_cnt;
`endif

  result_fifo #(
    .WIDTH (2 * ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_Start),
    .i_push  (w_push),
    .i_data  ({r_query_id, r_ref_id}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_Data     = w_fifo_data;
  assign o_Valid    = w_fifo_valid;
  assign o_Overflow = r_overflow;
  assign o_Done     = r_done;

endmodule

// File: tb/tb_match_collector.sv
// Directed bench for match_collector (ID_WIDTH=16, FIFO_DEPTH=4).
module tb_match_collector;

  localparam int IDW   = 16;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_Start = 1'b0;
  logic [IDW-1:0] i_RefCount = 16'd0;
  logic [IDW-1:0] i_QueryCount = 16'd0;
  logic           i_Valid = 1'b0;
  logic           i_Match = 1'b0;
  logic           i_Ready = 1'b0;
  logic [2*IDW-1:0] o_Data;
  logic           o_Valid;
  logic           o_Overflow;
  logic           o_Done;
`ifdef MATCH_COLLECTOR_CNT_EN
  logic [31:0]    o_MatchCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  match_collector #(
    .ID_WIDTH   (IDW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_Start      (i_Start),
    .i_RefCount   (i_RefCount),
    .i_QueryCount (i_QueryCount),
    .i_Valid      (i_Valid),
    .i_Match      (i_Match),
    .o_Data       (o_Data),
    .o_Valid      (o_Valid),
    .i_Ready      (i_Ready),
    .o_Overflow   (o_Overflow),
    .o_Done       (o_Done)
`ifdef MATCH_COLLECTOR_CNT_EN
    ,
    .o_MatchCnt   (o_MatchCnt)
`endif
  );

  typedef struct {
    logic        start;
    logic [15:0] rc;
    logic [15:0] qc;
    logic        valid;
    logic        match;
    logic        ready;
    logic        ev;     // expected o_Valid
    logic [31:0] ed;     // expected o_Data when ev
    logic        edone;
    logic        eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic [15:0] rc, input logic [15:0] qc,
                              input logic v, input logic m, input logic r,
                              input logic ev, input logic [31:0] ed,
                              input logic edone, input logic eovf);
    vec_t t;
    t.start = s; t.rc = rc; t.qc = qc; t.valid = v; t.match = m; t.ready = r;
    t.ev = ev; t.ed = ed; t.edone = edone; t.eovf = eovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [15:0] rc, input logic [15:0] qc,
                       input logic v, input logic m, input logic r);
    i_Start = s; i_RefCount = rc; i_QueryCount = qc;
    i_Valid = v; i_Match = m; i_Ready = r;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (o_Done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(o_Done | seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, checked asynchronously before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst.o_Valid", 32'(o_Valid), 32'd0);
    check("rst.o_Data", o_Data, 32'd0);
    check("rst.o_Overflow", 32'(o_Overflow), 32'd0);
    check("rst.o_Done", 32'(o_Done), 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // Run 1: RC=3, QC=2, matches at results 1 and 4, ready high.
    tbl.push_back(mk(1'b1, 16'd3, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0001_0001, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0));
    // Run 2: RC=6, QC=1, ready low, 6 matches -> 4 held, 2 dropped, then drain.
    tbl.push_back(mk(1'b1, 16'd6, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,          1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0003, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b1));
    // Run 3 (from DONE): FIFO full with push and pop on the same edge -> no drop.
    tbl.push_back(mk(1'b1, 16'd6, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0003, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].rc, tbl[i].qc, tbl[i].valid, tbl[i].match, tbl[i].ready);
      step();
      check($sformatf("vec%0d.o_Valid", i), 32'(o_Valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("vec%0d.o_Data", i), o_Data, tbl[i].ed);
      end
      check($sformatf("vec%0d.o_Done", i), 32'(o_Done), 32'(tbl[i].edone));
      check($sformatf("vec%0d.o_Overflow", i), 32'(o_Overflow), 32'(tbl[i].eovf));
    end

    // Zero RefCount: straight to DRAIN/DONE, later results ignored.
    drive(1'b1, 16'd0, 16'd5, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    step(); step();
    check("zero_ref.o_Done", 32'(o_Done), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
      step();
      check($sformatf("zero_ref.o_Valid%0d", k), 32'(o_Valid), 32'd0);
    end
    check("zero_ref.o_Done_hold", 32'(o_Done), 32'd1);
    // Zero QueryCount.
    drive(1'b1, 16'd3, 16'd0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
    step(); step();
    check("zero_qry.o_Done", 32'(o_Done), 32'd1);
    check("zero_qry.o_Valid", 32'(o_Valid), 32'd0);

    // Restart mid-run: overflowed run, then restart, then restart after 2 of 4.
    drive(1'b1, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
      step();
    end
    check("restart.pre_ovf", 32'(o_Overflow), 32'd1);
    check("restart.pre_valid", 32'(o_Valid), 32'd1);
`ifdef MATCH_COLLECTOR_CNT_EN
    check("restart.match_cnt", o_MatchCnt, 32'd6);
`endif
    drive(1'b1, 16'd4, 16'd1, 1'b0, 1'b0, 1'b0);
    step();
    check("restart.flush_valid", 32'(o_Valid), 32'd0);
    check("restart.ovf_clear", 32'(o_Overflow), 32'd0);
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("restart.first_valid", 32'(o_Valid), 32'd1);
    check("restart.first_pair", o_Data, 32'h0000_0000);
    drive(1'b1, 16'd4, 16'd1, 1'b0, 1'b0, 1'b0);
    step();
    check("restart2.flush_valid", 32'(o_Valid), 32'd0);
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("restart2.valid", 32'(o_Valid), 32'd1);
    check("restart2.pair", o_Data, 32'h0000_0001);
    drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    wait_done("restart2.done", 10);
    check("restart2.ovf", 32'(o_Overflow), 32'd0);

    // Asynchronous reset in DRAIN with o_Valid and o_Overflow high.
    drive(1'b1, 16'd6, 16'd1, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("arst.pre_valid", 32'(o_Valid), 32'd1);
    check("arst.pre_ovf", 32'(o_Overflow), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("arst.o_Valid", 32'(o_Valid), 32'd0);
    check("arst.o_Done", 32'(o_Done), 32'd0);
    check("arst.o_Overflow", 32'(o_Overflow), 32'd0);
    check("arst.o_Data", o_Data, 32'd0);
`ifdef MATCH_COLLECTOR_CNT_EN
    check("arst.o_MatchCnt", o_MatchCnt, 32'd0);
`endif
    step();
    rst = 1'b1;
    // In IDLE results are ignored.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
      step();
    end
    check("idle.o_Valid", 32'(o_Valid), 32'd0);
    check("idle.o_Done", 32'(o_Done), 32'd0);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
